// File: rtl/serial_sub_ctrl_if.sv
// Start/busy/done handshake and operand/result bus
// for the bit-serial subtractor.
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bout
  );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: D = A - B - BIN, one
// full-subtractor cell per clock, LSB first.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_sub_ctrl_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nx;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             ca;
  logic             cb;
  logic             cell_d;
  logic             cell_bo;

  assign ca      = sa[0];
  assign cb      = sb[0];
  assign cell_d  = ca ^ cb ^ brw;
  assign cell_bo = (~ca & cb) | (~(ca ^ cb) & brw);
  assign last    = (cnt == CW'(WIDTH - 1));

  // Result enters at the MSB so it is aligned after WIDTH steps.
  assign sr_nx = (sr >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (last) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      sr     <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      d_q    <= '0;
      bout_q <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            sa  <= bus.a;
            sb  <= bus.b;
            brw <= bus.bin;
            cnt <= '0;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sr  <= sr_nx;
          brw <= cell_bo;
          cnt <= cnt + CW'(1);
          if (last) begin
            d_q    <= sr_nx;
            bout_q <= cell_bo;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == FIN);
  assign bus.d    = d_q;
  assign bus.bout = bout_q;
endmodule
